// File: rtl/cla_pkg.sv
// Shared types and constants for the sequential lookahead subtractor.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int NIBBLE = 4;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; every internal carry is a
// flat sum of products of g/p and cin, so no ripple inside the nibble.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       p,
  output logic       g
);

  logic [3:0] p_bit;
  logic [3:0] g_bit;
  logic [3:0] c;

  always_comb begin
    p_bit = x ^ y;
    g_bit = x & y;
    c[0]  = cin;
    c[1]  = g_bit[0] | (p_bit[0] & cin);
    c[2]  = g_bit[1] | (p_bit[1] & g_bit[0]) | (p_bit[1] & p_bit[0] & cin);
    c[3]  = g_bit[2] | (p_bit[2] & g_bit[1]) | (p_bit[2] & p_bit[1] & g_bit[0])
          | (p_bit[2] & p_bit[1] & p_bit[0] & cin);
    p     = &p_bit;
    g     = g_bit[3] | (p_bit[3] & g_bit[2]) | (p_bit[3] & p_bit[2] & g_bit[1])
          | (p_bit[3] & p_bit[2] & p_bit[1] & g_bit[0]);
    cout  = g | (p & cin);
    s     = p_bit ^ c;
  end

endmodule

// File: rtl/seq_cla_subtractor.sv
// Multi-cycle subtractor: diff = a + ~b + 1, one nibble per clock through a
// single lookahead slice, behind a start/done handshake.
module seq_cla_subtractor
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int GROUPS = WIDTH / NIBBLE;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  sub_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] nb_sh_q, nb_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [3:0] slice_s;
  logic       slice_cout;
  logic       slice_p;
  logic       slice_g;
  logic       unused_group;
  logic       last_group;

  cla4_slice u_slice (
    .x    (a_sh_q[3:0]),
    .y    (nb_sh_q[3:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout),
    .p    (slice_p),
    .g    (slice_g)
  );

  // Group p/g exist for chaining wider lookahead trees; this design uses cout.
  assign unused_group = slice_p ^ slice_g;
  assign last_group   = (state_q == RUN) && (cnt_q == CNT_W'(GROUPS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last_group) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == RUN);
    done_o = (state_q == DONE);
  end

  always_comb begin
    cnt_d      = cnt_q;
    a_sh_d     = a_sh_q;
    nb_sh_d    = nb_sh_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    if (state_q == IDLE && start_i) begin
      a_sh_d  = a_i;
      nb_sh_d = ~b_i;
      acc_d   = '0;
      carry_d = 1'b1;
      cnt_d   = '0;
      a_msb_d = a_i[WIDTH-1];
      b_msb_d = b_i[WIDTH-1];
    end else if (state_q == RUN) begin
      acc_d[cnt_q*NIBBLE +: NIBBLE] = slice_s;
      carry_d = slice_cout;
      a_sh_d  = a_sh_q >> NIBBLE;
      nb_sh_d = nb_sh_q >> NIBBLE;
      cnt_d   = cnt_q + CNT_W'(1);
      // Results land on the last RUN edge so they are valid alongside done.
      if (last_group) begin
        diff_d     = acc_d;
        borrow_d   = ~slice_cout;
        overflow_d = (a_msb_q != b_msb_q) && (acc_d[WIDTH-1] != a_msb_q);
        zero_d     = (acc_d == '0);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      a_sh_q     <= '0;
      nb_sh_q    <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      a_sh_q     <= a_sh_d;
      nb_sh_q    <= nb_sh_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign diff_o     = diff_q;
  assign borrow_o   = borrow_q;
  assign overflow_o = overflow_q;
  assign zero_o     = zero_q;

endmodule

// File: tb/tb_seq_cla_subtractor.sv
// Directed bench for seq_cla_subtractor (WIDTH=16) with hand-computed results.
module tb_seq_cla_subtractor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] diff_o;
  logic        borrow_o;
  logic        overflow_o;
  logic        zero_o;

  int passes = 0;
  int total  = 0;
  int fails  = 0;

  seq_cla_subtractor #(.WIDTH(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .diff_o     (diff_o),
    .borrow_o   (borrow_o),
    .overflow_o (overflow_o),
    .zero_o     (zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or on timeout).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int edges);
    start_i = 1'b1;
    a_i     = a;
    b_i     = b;
    edges   = 0;
    @(posedge clk_i);
    edges++;
    @(negedge clk_i);
    start_i = 1'b0;
    while (!done_o && edges < 20) begin
      @(posedge clk_i);
      edges++;
      @(negedge clk_i);
    end
  endtask

  int edges;
  int dones;
  int gap;

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    repeat (2) @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_diff", diff_o, 0);
    check("rst_flags", {borrow_o, overflow_o, zero_o}, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_busy", busy_o, 0);

    run_op(16'h1234, 16'h0234, edges);
    check("t1_latency", edges, 5);
    check("t1_busy_in_done", busy_o, 0);
    check("t1_diff", diff_o, 16'h1000);
    check("t1_flags_bov_z", {borrow_o, overflow_o, zero_o}, 3'b000);
    @(negedge clk_i);
    check("t1_done_one_cycle", done_o, 0);
    check("t1_diff_held", diff_o, 16'h1000);

    run_op(16'h0000, 16'h0001, edges);
    check("t2_latency", edges, 5);
    check("t2_diff", diff_o, 16'hFFFF);
    check("t2_flags_bov_z", {borrow_o, overflow_o, zero_o}, 3'b100);
    @(negedge clk_i);

    run_op(16'h8000, 16'h0001, edges);
    check("t3_diff", diff_o, 16'h7FFF);
    check("t3_flags_bov_z", {borrow_o, overflow_o, zero_o}, 3'b010);
    @(negedge clk_i);

    run_op(16'hBEEF, 16'hBEEF, edges);
    check("t4_diff", diff_o, 16'h0000);
    check("t4_flags_bov_z", {borrow_o, overflow_o, zero_o}, 3'b001);
    @(negedge clk_i);

    run_op(16'h7FFF, 16'hFFFF, edges);
    check("t5_diff", diff_o, 16'h8000);
    check("t5_flags_bov_z", {borrow_o, overflow_o, zero_o}, 3'b110);
    @(negedge clk_i);

    // start pulses during RUN cycles 1 and 3 must be ignored
    start_i = 1'b1;
    a_i     = 16'h0005;
    b_i     = 16'h0003;
    @(negedge clk_i);
    check("t6_busy_run1", busy_o, 1);
    start_i = 1'b1;
    a_i     = 16'hFFFF;
    b_i     = 16'h0001;
    @(negedge clk_i);
    check("t6_busy_run2", busy_o, 1);
    start_i = 1'b0;
    @(negedge clk_i);
    check("t6_busy_run3", busy_o, 1);
    start_i = 1'b1;
    @(negedge clk_i);
    check("t6_busy_run4", busy_o, 1);
    start_i = 1'b0;
    @(negedge clk_i);
    check("t6_busy_done", busy_o, 0);
    check("t6_done", done_o, 1);
    check("t6_diff", diff_o, 16'h0002);
    dones = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    check("t6_no_second_done", dones, 0);
    check("t6_diff_held", diff_o, 16'h0002);

    // reset during RUN cycle 2
    start_i = 1'b1;
    a_i     = 16'h1234;
    b_i     = 16'h0234;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    check("t7_busy_before_rst", busy_o, 1);
    rst_i = 1'b1;
    #1;
    check("t7_rst_busy", busy_o, 0);
    check("t7_rst_done", done_o, 0);
    check("t7_rst_diff", diff_o, 0);
    check("t7_rst_flags", {borrow_o, overflow_o, zero_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    check("t7_no_done_after_rst", dones, 0);
    run_op(16'h0010, 16'h0001, edges);
    check("t7_fresh_latency", edges, 5);
    check("t7_fresh_diff", diff_o, 16'h000F);
    check("t7_fresh_borrow", borrow_o, 0);
    @(negedge clk_i);

    // start held high: back-to-back operations every 6 cycles
    run_op(16'h0003, 16'h0005, edges);
    start_i = 1'b1;
    check("t8_first_done", done_o, 1);
    check("t8_diff", diff_o, 16'hFFFE);
    check("t8_flags_bov_z", {borrow_o, overflow_o, zero_o}, 3'b100);
    gap = 0;
    do begin
      @(negedge clk_i);
      gap++;
    end while (!done_o && gap < 20);
    start_i = 1'b0;
    check("t8_back_to_back_gap", gap, 6);
    check("t8_second_diff", diff_o, 16'hFFFE);
    repeat (2) @(negedge clk_i);
    check("t8_idle_after", busy_o, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
